// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game blocks.
// Also provides the Galois LFSR step shared by every randomised block.
package dino_pkg;

    localparam int unsigned DINO_POS_W        = 10;
    localparam int unsigned SPEED_W           = 4;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        CACTUS_SMALL = 2'd0,
        CACTUS_LARGE = 2'd1,
        BIRD_LOW     = 2'd2,
        BIRD_HIGH    = 2'd3
    } obst_type_t;

    // Right-shifting Galois form: a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/dino_lfsr16.sv
// Free-running 16-bit Galois LFSR with a reset seed; a zero seed is replaced by
// the default seed so the register can never lock up.
module dino_lfsr16
    import dino_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Owns the two obstacle slots: spawns at GEN_LINE, scrolls one step per frame, retires off-screen.
// Build option: define DINO_SPEED_RAMP_EN to raise the scroll speed every RAMP_INTERVAL spawns.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int unsigned POS_W         = DINO_POS_W,
    parameter int unsigned GEN_LINE      = 250,
    parameter int unsigned MIN_GAP       = 40,
    parameter int unsigned BASE_SPEED    = 2,
    parameter int unsigned MAX_SPEED     = 6,
    parameter int unsigned RAMP_INTERVAL = 8,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               game_run,
    input  logic               restart,
    output logic [POS_W-1:0]   obstacle1_pos,
    output logic [POS_W-1:0]   obstacle2_pos,
    output logic [1:0]         obstacle1_type,
    output logic [1:0]         obstacle2_type,
    output logic               obstacle1_valid,
    output logic               obstacle2_valid,
    output logic [SPEED_W-1:0] speed,
    output logic               spawn_pulse
);

    localparam int unsigned NSLOT = 2;
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 64);

    logic [15:0]                  lfsr;
    logic                         tick;
    logic                         spawn_en;
    logic [NSLOT-1:0]             spawn_slot;
    logic [NSLOT-1:0]             slot_valid;
    logic [NSLOT-1:0][POS_W-1:0]  slot_pos;
    obst_type_t [NSLOT-1:0]       slot_type;
    logic [GAP_W-1:0]             gap_q, gap_d;
    logic                         spawn_pulse_q;
    logic [SPEED_W-1:0]           cur_speed;
    logic                         unused_lfsr;

    dino_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:8];

    // A restart pulse swallows a coincident frame tick entirely.
    assign tick = frame_tick && game_run && !restart;

    // Occupancy is sampled at tick start, so a slot retiring this tick is not yet free.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        spawn_slot = '0;
        spawn_en   = tick && (gap_q == '0) && !(&slot_valid);
        if (spawn_en) begin
            if (!slot_valid[0]) spawn_slot[0] = 1'b1;
            else                spawn_slot[1] = 1'b1;
        end
    end

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        logic [POS_W-1:0] pos_q, pos_d;
        logic             valid_q, valid_d;
        obst_type_t       type_q, type_d;

        always_comb begin
            pos_d   = pos_q;
            valid_d = valid_q;
            type_d  = type_q;
            if (spawn_slot[i]) begin
                valid_d = 1'b1;
                pos_d   = POS_W'(GEN_LINE);
                type_d  = obst_type_t'(lfsr[1:0]);
            end else if (tick && valid_q) begin
                if (pos_q <= POS_W'(cur_speed)) begin
                    valid_d = 1'b0;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q - POS_W'(cur_speed);
                end
            end
        end

        // NOTE: reset is synchronous; restart clears the same state as reset.
        always_ff @(posedge clk) begin
            if (!rst_n || restart) begin
                pos_q   <= '0;
                valid_q <= 1'b0;
                type_q  <= CACTUS_SMALL;
            end else begin
                pos_q   <= pos_d;
                valid_q <= valid_d;
                type_q  <= type_d;
            end
        end

        assign slot_valid[i] = valid_q;
        assign slot_pos[i]   = pos_q;
        assign slot_type[i]  = type_q;
    end

    // Gap holds at zero while both slots are busy; reload draws from the same LFSR sample as type.
    always_comb begin
        gap_d = gap_q;
        if (spawn_en) begin
            gap_d = GAP_W'(MIN_GAP) + GAP_W'(lfsr[7:2]);
        end else if (tick && (gap_q != '0)) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            gap_q         <= GAP_W'(MIN_GAP);
            spawn_pulse_q <= 1'b0;
        end else begin
            gap_q         <= gap_d;
            spawn_pulse_q <= spawn_en;
        end
    end

`ifdef DINO_SPEED_RAMP_EN
    localparam int unsigned RAMP_W = $clog2(RAMP_INTERVAL + 1);

    logic [RAMP_W-1:0]  ramp_cnt_q;
    logic [SPEED_W-1:0] speed_q;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            ramp_cnt_q <= '0;
            speed_q    <= SPEED_W'(BASE_SPEED);
        end else if (spawn_en) begin
            if (ramp_cnt_q == RAMP_W'(RAMP_INTERVAL - 1)) begin
                ramp_cnt_q <= '0;
                if (speed_q < SPEED_W'(MAX_SPEED)) speed_q <= speed_q + SPEED_W'(1);
            end else begin
                ramp_cnt_q <= ramp_cnt_q + RAMP_W'(1);
            end
        end
    end

    assign cur_speed = speed_q;
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{MAX_SPEED, RAMP_INTERVAL};
    assign cur_speed       = SPEED_W'(BASE_SPEED);
`endif

    assign obstacle1_pos   = slot_pos[0];
    assign obstacle2_pos   = slot_pos[1];
    assign obstacle1_type  = slot_type[0];
    assign obstacle2_type  = slot_type[1];
    assign obstacle1_valid = slot_valid[0];
    assign obstacle2_valid = slot_valid[1];
    assign speed           = cur_speed;
    assign spawn_pulse     = spawn_pulse_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler with a frame-level reference model
// of the two-slot field, including the spawn LFSR that picks type and gap.
module tb_obstacle_scheduler;

    localparam int GEN   = 250;
    localparam int MING  = 40;
    localparam int BASE  = 2;
    localparam int MAXS  = 6;
    localparam int RAMPI = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_run = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] o1_pos, o2_pos;
    logic [1:0] o1_type, o2_type;
    logic       o1_valid, o2_valid;
    logic [3:0] speed;
    logic       spawn_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .game_run        (game_run),
        .restart         (restart),
        .obstacle1_pos   (o1_pos),
        .obstacle2_pos   (o2_pos),
        .obstacle1_type  (o1_type),
        .obstacle2_type  (o2_type),
        .obstacle1_valid (o1_valid),
        .obstacle2_valid (o2_valid),
        .speed           (speed),
        .spawn_pulse     (spawn_pulse)
    );

    // ---------------- reference model (one step per clock) ----------------
    int          m_pos   [2];
    bit          m_valid [2];
    int          m_type  [2];
    int          m_gap;
    int          m_speed;
    int          m_ramp;
    int          m_spawns;
    bit          m_pulse;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] galois_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 2; s++) begin
            m_pos[s]   = 0;
            m_valid[s] = 1'b0;
            m_type[s]  = 0;
        end
        m_gap    = MING;
        m_speed  = BASE;
        m_ramp   = 0;
        m_spawns = 0;
        m_pulse  = 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [15:0] cur;
        int          sp;
        cur    = m_lfsr;
        m_lfsr = galois_step(cur);
        if (!rst_n) begin
            m_lfsr = 16'hACE1;
            model_clear();
        end else if (restart) begin
            model_clear();
        end else if (frame_tick && game_run) begin
            sp = -1;
            if (m_gap == 0) begin
                if (!m_valid[0])      sp = 0;
                else if (!m_valid[1]) sp = 1;
            end else begin
                m_gap = m_gap - 1;
            end
            for (int s = 0; s < 2; s++) begin
                if (m_valid[s]) begin
                    if (m_pos[s] <= m_speed) begin
                        m_valid[s] = 1'b0;
                        m_pos[s]   = 0;
                    end else begin
                        m_pos[s] = m_pos[s] - m_speed;
                    end
                end
            end
            m_pulse = (sp >= 0);
            if (sp >= 0) begin
                m_valid[sp] = 1'b1;
                m_pos[sp]   = GEN;
                m_type[sp]  = int'(cur[1:0]);
                m_gap       = MING + int'(cur[7:2]);
                m_spawns    = m_spawns + 1;
`ifdef DINO_SPEED_RAMP_EN
                m_ramp = m_ramp + 1;
                if (m_ramp == RAMPI) begin
                    m_ramp = 0;
                    if (m_speed < MAXS) m_speed = m_speed + 1;
                end
`endif
            end
        end else begin
            m_pulse = 1'b0;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cyc(input bit ft, input bit run, input bit rs);
        frame_tick = ft;
        game_run   = run;
        restart    = rs;
        @(negedge clk);
        frame_tick = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic idle_rand();
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (o1_pos !== 10'd0) begin bad++; $display("FAIL reset_o1_pos: got %0d want 0", o1_pos); end
        total++; if (o2_pos !== 10'd0) begin bad++; $display("FAIL reset_o2_pos: got %0d want 0", o2_pos); end
        total++; if ({o1_valid, o2_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b%b want 00", o1_valid, o2_valid); end
        total++; if ({o1_type, o2_type} !== 4'd0) begin bad++; $display("FAIL reset_type: got %0d/%0d want 0/0", o1_type, o2_type); end
        total++; if (spawn_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", spawn_pulse); end
        total++; if (speed !== 4'(BASE)) begin bad++; $display("FAIL reset_speed: got %0d want %0d", speed, BASE); end
    endtask

    task automatic test_first_spawn();
        int pulses;
        pulses = 0;
        for (int t = 0; t < MING; t++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (spawn_pulse === 1'b1) pulses++;
            idle_rand();
        end
        total++; if (o1_valid !== 1'b0) begin bad++; $display("FAIL spawn_before_gap: valid=%b want 0", o1_valid); end
        cyc(1'b1, 1'b1, 1'b0);
        if (spawn_pulse === 1'b1) pulses++;
        total++; if (o1_valid !== 1'b1) begin bad++; $display("FAIL first_spawn_valid: got %b want 1", o1_valid); end
        total++; if (o1_pos !== 10'(GEN)) begin bad++; $display("FAIL first_spawn_pos: got %0d want %0d", o1_pos, GEN); end
        total++; if (o1_type !== 2'(m_type[0])) begin bad++; $display("FAIL first_spawn_type: got %0d want %0d", o1_type, m_type[0]); end
        total++; if ({o2_valid, o2_pos} !== 11'd0) begin bad++; $display("FAIL first_spawn_slot2: valid=%b pos=%0d want empty", o2_valid, o2_pos); end
        total++; if (speed !== 4'(BASE)) begin bad++; $display("FAIL first_spawn_speed: got %0d want %0d", speed, BASE); end
        cyc(1'b0, 1'b1, 1'b0);
        total++; if (pulses !== 1 || spawn_pulse !== 1'b0) begin bad++; $display("FAIL first_spawn_pulse: pulses=%0d now=%b want 1/0", pulses, spawn_pulse); end
    endtask

    task automatic test_scroll_freeze();
        for (int t = 0; t < 10; t++) begin
            cyc(1'b1, 1'b1, 1'b0);
            idle_rand();
        end
        total++; if (o1_pos !== 10'd230) begin bad++; $display("FAIL scroll_pos: got %0d want 230", o1_pos); end
        for (int t = 0; t < 100; t++) cyc(1'b1, 1'b0, 1'b0);
        total++; if (o1_pos !== 10'd230 || o1_valid !== 1'b1) begin bad++; $display("FAIL freeze_pos: got %0d valid=%b want 230 valid=1", o1_pos, o1_valid); end
        total++; if (o2_pos !== 10'(m_pos[1])) begin bad++; $display("FAIL freeze_slot2: got %0d want %0d", o2_pos, m_pos[1]); end
    endtask

    task automatic test_retire_boundary();
        int guard;
        guard = 0;
        while (!(m_valid[0] && m_pos[0] == 4) && guard < 400) begin
            cyc(1'b1, 1'b1, 1'b0);
            guard++;
        end
        total++;
        if (guard >= 400) begin
            bad++; $display("FAIL retire_timeout: model slot1 pos=%0d never reached 4", m_pos[0]);
        end else begin
            if (o1_pos !== 10'd4) begin bad++; $display("FAIL retire_pre_pos: got %0d want 4", o1_pos); end
            cyc(1'b1, 1'b1, 1'b0);
            total++; if (o1_pos !== 10'd2 || o1_valid !== 1'b1) begin bad++; $display("FAIL retire_above_speed: pos=%0d valid=%b want 2/1", o1_pos, o1_valid); end
            cyc(1'b1, 1'b1, 1'b0);
            total++; if (o1_pos !== 10'd0 || o1_valid !== 1'b0) begin bad++; $display("FAIL retire_at_speed: pos=%0d valid=%b want 0/0", o1_pos, o1_valid); end
        end
    endtask

    task automatic test_refill_after_retire();
        int guard;
        int r;
        guard = 0;
        while (!(m_valid[0] && m_valid[1] && m_gap == 0) && guard < 6000) begin
            cyc(1'b1, 1'b1, 1'b0);
            idle_rand();
            guard++;
        end
        total++;
        if (guard >= 6000) begin
            bad++; $display("FAIL refill_timeout: never saw both slots full with gap 0");
            return;
        end
        guard = 0;
        while (m_pos[0] > m_speed && m_pos[1] > m_speed && guard < 400) begin
            cyc(1'b1, 1'b1, 1'b0);
            guard++;
        end
        r = (m_pos[0] <= m_speed) ? 0 : 1;
        cyc(1'b1, 1'b1, 1'b0);
        total++; if ((r == 0 ? o1_valid : o2_valid) !== 1'b0 || spawn_pulse !== 1'b0) begin
            bad++; $display("FAIL refill_same_tick: slot%0d valid=%b pulse=%b want 0/0", r + 1, (r == 0 ? o1_valid : o2_valid), spawn_pulse);
        end
        cyc(1'b1, 1'b1, 1'b0);
        total++; if ((r == 0 ? o1_valid : o2_valid) !== 1'b1 || (r == 0 ? o1_pos : o2_pos) !== 10'(GEN) || spawn_pulse !== 1'b1) begin
            bad++; $display("FAIL refill_next_tick: slot%0d valid=%b pos=%0d pulse=%b want 1/%0d/1", r + 1,
                            (r == 0 ? o1_valid : o2_valid), (r == 0 ? o1_pos : o2_pos), spawn_pulse, GEN);
        end
    endtask

    task automatic test_restart();
        cyc(1'b1, 1'b1, 1'b1);
        total++; if ({o1_valid, o2_valid} !== 2'b00 || o1_pos !== 10'd0 || o2_pos !== 10'd0) begin
            bad++; $display("FAIL restart_clear: valid=%b%b pos=%0d/%0d want empty", o1_valid, o2_valid, o1_pos, o2_pos);
        end
        total++; if (spawn_pulse !== 1'b0 || speed !== 4'(BASE)) begin bad++; $display("FAIL restart_pulse_speed: pulse=%b speed=%0d want 0/%0d", spawn_pulse, speed, BASE); end
        for (int t = 0; t < MING; t++) cyc(1'b1, 1'b1, 1'b0);
        total++; if (o1_valid !== 1'b0) begin bad++; $display("FAIL restart_gap_early: valid=%b want 0", o1_valid); end
        cyc(1'b1, 1'b1, 1'b0);
        total++; if (o1_valid !== 1'b1 || o1_pos !== 10'(GEN)) begin bad++; $display("FAIL restart_gap_spawn: valid=%b pos=%0d want 1/%0d", o1_valid, o1_pos, GEN); end
    endtask

    task automatic test_speed();
        int guard;
        int want;
        cyc(1'b0, 1'b1, 1'b1);
        guard = 0;
`ifdef DINO_SPEED_RAMP_EN
        while (m_spawns < 8 && guard < 20000) begin cyc(1'b1, 1'b1, 1'b0); guard++; end
        want = 3;
        total++; if (speed !== 4'(want)) begin bad++; $display("FAIL ramp_8: got %0d want %0d", speed, want); end
        while (m_spawns < 32 && guard < 20000) begin cyc(1'b1, 1'b1, 1'b0); guard++; end
        want = MAXS;
        total++; if (speed !== 4'(want) || guard >= 20000) begin bad++; $display("FAIL ramp_32: got %0d want %0d", speed, want); end
`else
        while (m_spawns < 12 && guard < 20000) begin
            cyc(1'b1, 1'b1, 1'b0);
            guard++;
        end
        want = BASE;
        total++; if (speed !== 4'(want) || m_spawns < 12) begin bad++; $display("FAIL speed_const: got %0d after %0d spawns want %0d", speed, m_spawns, want); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 299) == 0));
            total++; if (o1_valid !== m_valid[0] || o1_pos !== 10'(m_pos[0])) begin
                bad++; $display("FAIL rand_slot1 c=%0d: valid=%b pos=%0d want %b/%0d", c, o1_valid, o1_pos, m_valid[0], m_pos[0]);
            end
            total++; if (o2_valid !== m_valid[1] || o2_pos !== 10'(m_pos[1])) begin
                bad++; $display("FAIL rand_slot2 c=%0d: valid=%b pos=%0d want %b/%0d", c, o2_valid, o2_pos, m_valid[1], m_pos[1]);
            end
            total++; if ((m_valid[0] && o1_type !== 2'(m_type[0])) || (m_valid[1] && o2_type !== 2'(m_type[1]))) begin
                bad++; $display("FAIL rand_type c=%0d: got %0d/%0d want %0d/%0d", c, o1_type, o2_type, m_type[0], m_type[1]);
            end
            total++; if (spawn_pulse !== m_pulse || speed !== 4'(m_speed)) begin
                bad++; $display("FAIL rand_pulse_speed c=%0d: pulse=%b speed=%0d want %b/%0d", c, spawn_pulse, speed, m_pulse, m_speed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_scroll_freeze();
        test_retire_boundary();
        test_refill_after_retire();
        test_restart();
        test_speed();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
